// File: rtl/flash_audio_pkg.sv
// rtl/flash_audio_pkg.sv - shared types and constants for flash audio consumers
//
// Holds the address/lane types, the reader state encoding and the
// all-lanes byteenable constant used by every flash read port.
package flash_audio_pkg;

  typedef logic [22:0] flash_addr_t;
  typedef logic [1:0]  byte_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    PRESENT,
    ADVANCE,
    SETTLE
  } rd_state_t;

  localparam logic [3:0] FLASH_BYTEENABLE_ALL = 4'b1111;

endpackage

// File: rtl/byte_lane_mux.sv
// rtl/byte_lane_mux.sv - combinational byte lane select from a flash word
//
// Ports:
//   word      in  WORD_W  flash read word
//   lane      in  2       byte lane (0 = bits [7:0], 3 = bits [31:24])
//   lane_byte out 8       selected byte
module byte_lane_mux
  import flash_audio_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] word,
  input  byte_sel_t         lane,
  output logic [7:0]        lane_byte
);

  always_comb begin
    lane_byte = word[8*lane +: 8];
  end

endmodule

// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - reads flash words and hands out byte samples
//
// Follows the flash address sequencer: reads the current word over
// Avalon-MM, selects the current byte lane and offers it on a
// valid/ready port, then pulses advance to step the sequencer.
// Optional build macro FLASH_SAMPLE_READER_CACHE_EN reuses the buffered
// word when the sequencer stays inside the same flash word.
//
// Ports:
//   clk, reset (async, active-low)
//   seq_address/seq_byte        in   sequencer word address and lane
//   advance                     out  one-cycle step pulse to sequencer
//   flash_mem_*                      Avalon-MM read master
//   sample/sample_valid/ready        audio sample handshake
//   timeout_count               out  saturating read-timeout count
module flash_sample_reader
  import flash_audio_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] seq_address,
  input  logic [1:0]        seq_byte,
  output logic              advance,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [7:0]        sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [7:0]        timeout_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              cv_q, cv_d;
  logic [7:0]        sample_q, sample_d;
  logic [7:0]        tcount_q, tcount_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic [DATA_W-1:0] mux_word;
  logic [7:0]        mux_byte;
  logic              cache_hit;

  // On a fresh read the byte comes straight from the bus in the same cycle
  // the word is latched; on a cache hit it comes from the buffer.
  assign mux_word = (state_q == WAIT_DATA) ? flash_mem_readdata : buf_q;

  byte_lane_mux #(.WORD_W(DATA_W)) u_lane_mux (
    .word      (mux_word),
    .lane      (seq_byte),
    .lane_byte (mux_byte)
  );

`ifdef FLASH_SAMPLE_READER_CACHE_EN
  assign cache_hit = cv_q && (seq_address == addr_q);
`else
  // Flag kept as a live register so both builds share one state set.
  assign cache_hit = cv_q & 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    cv_d     = cv_q;
    sample_d = sample_q;
    tcount_d = tcount_q;
    timer_d  = timer_q;
    unique case (state_q)
      IDLE: begin
        addr_d  = seq_address;
        state_d = REQ;
      end
      REQ: begin
        timer_d = '0;
        if (!flash_mem_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        // Data beats a coincident timeout: checked first.
        if (flash_mem_readdatavalid) begin
          buf_d    = flash_mem_readdata;
          cv_d     = 1'b1;
          timer_d  = '0;
          sample_d = mux_byte;
          state_d  = PRESENT;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
          timer_d = '0;
          if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
          state_d = REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRESENT: begin
        if (sample_ready) state_d = ADVANCE;
      end
      ADVANCE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cache_hit) begin
          sample_d = mux_byte;
          state_d  = PRESENT;
        end else begin
          addr_d  = seq_address;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      buf_q    <= '0;
      cv_q     <= 1'b0;
      sample_q <= '0;
      tcount_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      cv_q     <= cv_d;
      sample_q <= sample_d;
      tcount_q <= tcount_d;
      timer_q  <= timer_d;
    end
  end

  assign flash_mem_read       = (state_q == REQ);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = FLASH_BYTEENABLE_ALL;
  assign sample_valid         = (state_q == PRESENT);
  assign advance              = (state_q == ADVANCE);
  assign sample               = sample_q;
  assign timeout_count        = tcount_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb/tb_flash_sample_reader.sv - scoreboard bench for flash_sample_reader
module tb_flash_sample_reader;

`ifdef FLASH_SAMPLE_READER_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] seq_address;
  logic [1:0]  seq_byte;
  logic        advance;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  timeout_count;

  flash_sample_reader dut (
    .clk                     (clk),
    .reset                   (rst_n),
    .seq_address             (seq_address),
    .seq_byte                (seq_byte),
    .advance                 (advance),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .sample                  (sample),
    .sample_valid            (sample_valid),
    .sample_ready            (sample_ready),
    .timeout_count           (timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rd_accepts = 0;
  int adv_cnt = 0;

  logic [7:0]  sb_q[$];
  logic [22:0] model_addr;
  logic [31:0] model_buf;
  logic        model_cv;
  logic [22:0] nxt_addr;
  logic [1:0]  nxt_byte;

  always @(posedge clk) begin
    if (rst_n && flash_mem_read && !flash_mem_waitrequest) rd_accepts <= rd_accepts + 1;
    if (advance) adv_cnt <= adv_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [22:0] a);
    if (a == 23'h000010 || a == 23'h000020) return 32'hDDCCBBAA;
    return {a[7:0] ^ 8'hA5, a[7:0], ~a[7:0], 8'h5A};
  endfunction

  task automatic accept_read(input int stall, input logic [22:0] exp_addr);
    int n = 0;
    flash_mem_waitrequest = 1'b1;
    while (!flash_mem_read && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq("read_req", {31'd0, flash_mem_read}, 32'd1);
    check_eq("read_addr", {9'd0, flash_mem_address}, {9'd0, exp_addr});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("read_held", {31'd0, flash_mem_read}, 32'd1);
      check_eq("addr_held", {9'd0, flash_mem_address}, {9'd0, exp_addr});
    end
    flash_mem_waitrequest = 1'b0;
    @(negedge clk);
    flash_mem_waitrequest = 1'b1;
    check_eq("read_drop", {31'd0, flash_mem_read}, 32'd0);
    model_addr = exp_addr;
  endtask

  task automatic give_data();
    logic [31:0] w;
    w = model_word(model_addr);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = w;
    sb_q.push_back(w[8*seq_byte +: 8]);
    model_buf = w;
    model_cv  = 1'b1;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = $urandom;
    check_eq("valid_latency", {31'd0, sample_valid}, 32'd1);
  endtask

  task automatic take_sample(input int hold);
    int n = 0;
    logic [7:0] s0;
    logic [7:0] exp;
    sample_ready = 1'b0;
    while (!sample_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_wait", {31'd0, sample_valid}, 32'd1);
    s0 = sample;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("sample_stable", {24'd0, sample}, {24'd0, s0});
      check_eq("no_advance", {31'd0, advance}, 32'd0);
    end
    sample_ready = 1'b1;
    check_eq("sb_size", sb_q.size(), 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    check_eq("sample", {24'd0, sample}, {24'd0, exp});
    @(negedge clk);
    sample_ready = 1'b0;
    check_eq("advance_pulse", {31'd0, advance}, 32'd1);
    check_eq("valid_drop", {31'd0, sample_valid}, 32'd0);
    seq_address = nxt_addr;
    seq_byte    = nxt_byte;
    @(negedge clk);
    check_eq("advance_single", {31'd0, advance}, 32'd0);
  endtask

  task automatic one_sample(input int hold, input logic [22:0] na, input logic [1:0] nb);
    if (CACHE_EN && model_cv && seq_address == model_addr) begin
      sb_q.push_back(model_buf[8*seq_byte +: 8]);
    end else begin
      accept_read(0, seq_address);
      give_data();
    end
    nxt_addr = na;
    nxt_byte = nb;
    take_sample(hold);
  endtask

  initial begin
    int base;
    int adv_base;
    int n;
    rst_n                   = 1'b0;
    seq_address             = 23'h000010;
    seq_byte                = 2'd2;
    flash_mem_waitrequest   = 1'b1;
    flash_mem_readdata      = '0;
    flash_mem_readdatavalid = 1'b0;
    sample_ready            = 1'b0;
    model_cv                = 1'b0;
    model_addr              = '0;
    model_buf               = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_read", {31'd0, flash_mem_read}, 32'd0);
    check_eq("rst_advance", {31'd0, advance}, 32'd0);
    check_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_sample", {24'd0, sample}, 32'd0);
    check_eq("rst_addr", {9'd0, flash_mem_address}, 32'd0);
    check_eq("rst_tcount", {24'd0, timeout_count}, 32'd0);
    check_eq("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
    rst_n = 1'b1;

    // First read with a 3-cycle stall, lane 2, slow consumer.
    accept_read(3, 23'h000010);
    check_eq("p1_reads", rd_accepts, 32'd1);
    give_data();
    nxt_addr = 23'h000020;
    nxt_byte = 2'd0;
    take_sample(5);

    // Bytes 0..3 of one word.
    base = rd_accepts;
    for (int b = 0; b < 4; b++) begin
      if (b < 3) one_sample(1, 23'h000020, 2'(b + 1));
      else       one_sample(1, 23'h000030, 2'd1);
    end
    check_eq("word_reads", rd_accepts - base, CACHE_EN ? 32'd1 : 32'd4);

    // Withheld data: timeout then re-issue; ready held high meanwhile.
    base     = rd_accepts;
    adv_base = adv_cnt;
    sample_ready = 1'b1;
    accept_read(0, 23'h000030);
    n = 0;
    while (!flash_mem_read && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_cycles", n, 32'd256);
    check_eq("timeout_count", {24'd0, timeout_count}, 32'd1);
    check_eq("ready_no_effect", adv_cnt - adv_base, 32'd0);
    accept_read(0, 23'h000030);
    give_data();
    nxt_addr = 23'h000040;
    nxt_byte = 2'd3;
    take_sample(0);
    check_eq("timeout_reads", rd_accepts - base, 32'd2);

    // Reset during WAIT_DATA, stray data after release.
    accept_read(0, 23'h000040);
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    model_cv = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_tcount", {24'd0, timeout_count}, 32'd0);
    check_eq("mid_rst_read", {31'd0, flash_mem_read}, 32'd0);
    rst_n                   = 1'b1;
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = 32'hFFFFFFFF;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    check_eq("stray_ignored", {31'd0, sample_valid}, 32'd0);
    check_eq("reissue_read", {31'd0, flash_mem_read}, 32'd1);
    check_eq("post_rst_tcount", {24'd0, timeout_count}, 32'd0);
    one_sample(2, 23'h000050, 2'd0);

    check_eq("sb_drained", sb_q.size(), 32'd0);
    check_eq("advance_total", adv_cnt, 32'd7);
    check_eq("reads_total", rd_accepts, CACHE_EN ? 32'd6 : 32'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Consumer stage directly downstream of the flash word/byte address sequencer (`flash_fsm`).
- Takes the sequencer's current word address and byte lane, issues an Avalon-MM read to the flash controller, and extracts the selected byte from the 32-bit read data.
- Presents the byte to the audio path over a valid/ready handshake.
- Pulses `advance` into the sequencer's `enable` once each sample is accepted.

Parameters:
- ADDR_W, 23, flash word address width.
- DATA_W, 32, flash read data width; 4 byte lanes.
- TIMEOUT_CYC, 255, cycles to wait for `flash_mem_readdatavalid` before re-issuing the read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- seq_address  in  ADDR_W  current word address from the sequencer
- seq_byte  in  2  current byte lane from the sequencer
- advance  out  1  one-cycle pulse; drives the sequencer's `enable`
- flash_mem_read  out  1  Avalon read request
- flash_mem_address  out  ADDR_W  registered read address
- flash_mem_byteenable  out  4  constant 4'b1111
- flash_mem_waitrequest  in  1  Avalon stall
- flash_mem_readdata  in  DATA_W  read data
- flash_mem_readdatavalid  in  1  read data strobe
- sample  out  8  extracted byte
- sample_valid  out  1  sample available
- sample_ready  in  1  audio path accepts the sample
- timeout_count  out  8  saturating count of read timeouts

Behaviour:
- Reset (`reset` = 0, async) forces all of the following:
  - state IDLE
  - `flash_mem_read`, `advance`, `sample_valid` = 0
  - `sample`, `flash_mem_address`, `timeout_count`, word buffer = 0
  - cache-valid flag = 0
- Reset is honoured mid-operation: any outstanding read is abandoned. A later `readdatavalid` is ignored unless the block is in WAIT_DATA.
- States:
  - IDLE: next cycle → REQ. Captures `seq_address` into `flash_mem_address`.
  - REQ: `flash_mem_read` = 1 and address held stable while `waitrequest` = 1. First cycle with `waitrequest` = 0 → WAIT_DATA; `read` drops the following cycle.
  - WAIT_DATA:
    - On `readdatavalid`: latch `readdata` into the word buffer, set cache-valid, clear the timer → PRESENT.
    - Otherwise the timer increments. When timer = TIMEOUT_CYC: `timeout_count` += 1 (saturates at 255) → REQ, same address.
  - PRESENT:
    - On entry, `sample` = buffer[8*seq_byte +: 8] (lane 0 = bits [7:0], lane 3 = bits [31:24]).
    - `sample_valid` = 1 and `sample` held stable until `sample_ready` = 1.
    - Handshake completes in the cycle both are high → ADVANCE.
  - ADVANCE: `advance` = 1 for exactly one cycle; `sample_valid` = 0 → SETTLE.
  - SETTLE: one cycle for the sequencer to register its new address/lane, then:
    - if the cache hit condition holds (see Optional Feature) → PRESENT;
    - otherwise capture `seq_address` → REQ.
- Latency: REQ accept to `sample_valid` = 1 is 1 cycle after `readdatavalid`. Minimum sample period is 3 cycles on a cache hit (PRESENT, ADVANCE, SETTLE).
- Sequencer wrap-around (address returning to its base) needs no special handling; it reads as a new address.
- `readdatavalid` in the same cycle as a timeout: the data wins. It is latched and the timeout is not counted.
- `sample_ready` high while `sample_valid` = 0 has no effect.
- No more than one read is outstanding at any time.

Optional Feature:
- Macro: FLASH_SAMPLE_READER_CACHE_EN.
- Defined:
  - In SETTLE, if cache-valid = 1 and `seq_address` == `flash_mem_address`, skip the flash access and go to PRESENT using the buffered word.
  - Yields 4 samples per flash read in forward or reverse byte order.
- Undefined:
  - SETTLE always → REQ; every sample costs one flash read.
  - Cache-valid flag still exists but is unused.

Decomposition:
- Shared package `flash_audio_pkg` holds:
  - `flash_addr_t` (logic [22:0]), `byte_sel_t` (logic [1:0]);
  - enum `rd_state_t` {IDLE, REQ, WAIT_DATA, PRESENT, ADVANCE, SETTLE};
  - constant FLASH_BYTEENABLE_ALL = 4'b1111.
- One sub-module is natural: `byte_lane_mux` (combinational 32→8 lane select), reused by other flash consumers.

Test Plan:
- Reset then release; `waitrequest` = 1 for 3 cycles:
  - `read` held, `flash_mem_address` = `seq_address` = 23'h000010;
  - exactly one read accepted.
- `readdata` = 32'hDDCCBBAA, `seq_byte` = 2 → `sample` = 8'hCC, `sample_valid` 1 cycle after `readdatavalid`.
- `sample_ready` held low 5 cycles:
  - `sample` stable, no `advance`;
  - on ready, exactly one `advance` pulse, then `sample_valid` = 0.
- CACHE_EN defined, sequencer steps bytes 0→3 within word 23'h000020 → 1 flash read, 4 samples AA, BB, CC, DD. Undefined → 4 reads.
- `readdatavalid` withheld 255 cycles → `timeout_count` = 1, read re-issued at the same address; data then accepted normally.
- Assert `reset` = 0 during WAIT_DATA, deliver a stray `readdatavalid` after release → ignored, new read issued, `timeout_count` = 0.
